// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM call arbiter: dispatcher states and call-vector bit positions.
package sdram_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        CALL,
        DONE
    } arbState_t;

    localparam int unsigned CALL_INIT     = 0;
    localparam int unsigned CALL_REF      = 1;
    localparam int unsigned CALL_REQ_BASE = 2;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises a single pending flag every REF_CYCLES clocks
// while enabled, and records a sticky overrun if an interval expires with refresh still pending.
module sdram_ref_timer #(
    parameter int unsigned REF_CYCLES = 780
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic grantClr,
    output logic pending,
    output logic overrun
);

    localparam int unsigned    CW   = $clog2(REF_CYCLES);
    localparam logic [CW-1:0]  TERM = CW'(REF_CYCLES - 1);

    logic [CW-1:0] count;
    logic          terminal;

    assign terminal = enable && (count == TERM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (!enable || terminal) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end

            // A terminal count on the grant cycle re-arms pending rather than clearing it.
            if (terminal) begin
                pending <= 1'b1;
            end else if (grantClr) begin
                pending <= 1'b0;
            end

            if (terminal && pending && !grantClr) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_call_arbiter.sv
// SDRAM call dispatcher: runs init once, then grants refresh or one requester at a time as a one-hot call.
// Define SDRAM_ARB_RR_EN for round-robin requester arbitration; otherwise lowest index wins.
module sdram_call_arbiter
    import sdram_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned REF_CYCLES = 780
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   iCall,
    input  logic               iDone,
    output logic [N_REQ+1:0]   oCall,
    output logic [N_REQ-1:0]   oDone,
    output logic               oBusy,
    output logic               oRefOverrun
);

    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arbState_t        state, stateNext;
    logic [N_REQ+1:0] callNext;
    logic [N_REQ-1:0] doneNext;
    logic [GW-1:0]    grant, grantNext, winner;
    logic             anyReq;
    logic             refPending;
    logic             refGrant;

    sdram_ref_timer #(
        .REF_CYCLES (REF_CYCLES)
    ) u_refTimer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (state != INIT),
        .grantClr (refGrant),
        .pending  (refPending),
        .overrun  (oRefOverrun)
    );

`ifdef SDRAM_ARB_RR_EN
    logic [GW-1:0] rrPtr;

    always_comb begin
        logic [GW-1:0] idx;
        idx    = '0;
        winner = '0;
        anyReq = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = GW'((32'(rrPtr) + 1 + i) % N_REQ);
            if (!anyReq && iCall[idx]) begin
                winner = idx;
                anyReq = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rrPtr <= GW'(N_REQ - 1);
        end else if (state == IDLE && !refPending && anyReq) begin
            rrPtr <= winner;
        end
    end
`else
    always_comb begin
        winner = '0;
        anyReq = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!anyReq && iCall[GW'(i)]) begin
                winner = GW'(i);
                anyReq = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        stateNext = state;
        callNext  = '0;
        doneNext  = '0;
        grantNext = grant;
        refGrant  = 1'b0;
        unique case (state)
            INIT: begin
                if (iDone) begin
                    stateNext = IDLE;
                end else begin
                    callNext[CALL_INIT] = 1'b1;
                end
            end
            IDLE: begin
                if (refPending) begin
                    stateNext          = CALL;
                    callNext[CALL_REF] = 1'b1;
                    refGrant           = 1'b1;
                end else if (anyReq) begin
                    stateNext                        = CALL;
                    callNext[CALL_REQ_BASE +: N_REQ] = N_REQ'(1) << winner;
                    grantNext                        = winner;
                end
            end
            CALL: begin
                if (iDone) begin
                    stateNext = DONE;
                    // The held call vector tells whether this was a refresh or a requester grant.
                    if (!oCall[CALL_REF]) begin
                        doneNext = N_REQ'(1) << grant;
                    end
                end else begin
                    callNext = oCall;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            oCall <= '0;
            oDone <= '0;
            grant <= '0;
        end else begin
            state <= stateNext;
            oCall <= callNext;
            oDone <= doneNext;
            grant <= grantNext;
        end
    end

    assign oBusy = (state != IDLE);

endmodule
